// File: rtl/key_debounce_tick_pkg.sv
// Shared types and constants for the tick-sampled key debouncer.
// State encoding, the default stability depth and the counter width helper.
package key_debounce_tick_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int STABLE_TICKS_DEFAULT = 20;

  // Wide enough to hold STABLE_TICKS; the counter itself never passes STABLE_TICKS-1.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/key_debounce_tick_if.sv
// Key-side bundle of the debouncer: raw pins in, clean level and pulses out.
// The debouncer is the slave; the entry logic / bench drives the raw pins as master.
interface key_debounce_tick_if #(
  parameter int NUM_KEYS = 4
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                tick;

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  tick
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output tick
  );

endinterface

// File: rtl/key_debounce_fsm.sv
// Single-key debounce FSM: accepts a level change only after STABLE_TICKS
// consecutive tick samples agree, and emits registered level and edge pulses.
module key_debounce_fsm
  import key_debounce_tick_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]   ONE  = CW'(1);
  localparam logic [CW-1:0]   LAST = CW'(STABLE_TICKS - 1);

  key_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;

  // NOTE: state, counter and outputs all use non-blocking assignments so every
  // branch reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (tick_i) begin
        case (state_q)
          RELEASED: begin
            if (key_i) begin
              cnt_q   <= ONE;
              state_q <= PRESS_WAIT;
            end
          end
          PRESS_WAIT: begin
            if (!key_i) begin
              cnt_q   <= '0;
              state_q <= RELEASED;
            end else if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= PRESSED;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          PRESSED: begin
            if (!key_i) begin
              cnt_q   <= ONE;
              state_q <= RELEASE_WAIT;
            end
          end
          RELEASE_WAIT: begin
            // Bounce back to pressed keeps the level high and emits nothing.
            if (key_i) begin
              cnt_q   <= '0;
              state_q <= PRESSED;
            end else if (cnt_q == LAST) begin
              cnt_q     <= '0;
              state_q   <= RELEASED;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce_tick.sv
// Debouncer top: turns the 1 kHz divided clock into a one-cycle sample strobe,
// synchronises the raw keys and runs one debounce FSM per key.
module key_debounce_tick
  import key_debounce_tick_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               slow_clk,
  key_debounce_tick_if.slave bus
);

  logic                slow_meta_q;
  logic                slow_sync_q;
  logic                slow_prev_q;
  logic                tick_q;
  logic                tick_d;
  logic [NUM_KEYS-1:0] key_meta_q;
  logic [NUM_KEYS-1:0] key_sync_q;
  logic [NUM_KEYS-1:0] key_s;
  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] press_w;
  logic [NUM_KEYS-1:0] release_w;

  // slow_clk is only ever data here; its synced rising edge becomes the strobe.
  assign tick_d = slow_sync_q & ~slow_prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slow_meta_q <= 1'b0;
      slow_sync_q <= 1'b0;
      slow_prev_q <= 1'b0;
      tick_q      <= 1'b0;
      key_meta_q  <= '0;
      key_sync_q  <= '0;
    end else begin
      slow_meta_q <= slow_clk;
      slow_sync_q <= slow_meta_q;
      slow_prev_q <= slow_sync_q;
      tick_q      <= tick_d;
      key_meta_q  <= bus.key_raw;
      key_sync_q  <= key_meta_q;
    end
  end

  assign key_s = (ACTIVE_LOW != 0) ? ~key_sync_q : key_sync_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_fsm #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_fsm (
      .clock    (clock),
      .reset    (reset),
      .tick_i   (tick_q),
      .key_i    (key_s[i]),
      .level_o  (level_w[i]),
      .press_o  (press_w[i]),
      .release_o(release_w[i])
    );
  end

  assign bus.key_level   = level_w;
  assign bus.key_press   = press_w;
  assign bus.key_release = release_w;
  assign bus.tick        = tick_q;

endmodule

// File: tb/tb_key_debounce_tick.sv
// Bench for key_debounce_tick: a streak-count model of each key checked every
// cycle, plus directed scenarios with hand-computed tick counts and pulse shapes.
module tb_key_debounce_tick;

  localparam int NK = 4;
  localparam int ST = 4;
  localparam int AL = 1;

  logic clock    = 1'b0;
  logic reset    = 1'b0;
  logic slow_clk = 1'b0;
  logic slow_run = 1'b0;

  key_debounce_tick_if #(.NUM_KEYS(NK)) bus ();

  key_debounce_tick #(
    .NUM_KEYS    (NK),
    .STABLE_TICKS(ST),
    .ACTIVE_LOW  (AL)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .slow_clk(slow_clk),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pins are seen through a fixed pipeline delay; each key keeps an accepted
  // level and the length of the current run of tick samples disagreeing with it.
  logic          s_hist [4];
  logic [NK-1:0] kh     [2];
  logic          exp_tick;
  logic [NK-1:0] exp_level;
  logic [NK-1:0] exp_press;
  logic [NK-1:0] exp_release;
  int            streak [NK];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) s_hist[i] = 1'b0;
    kh[0] = '0;
    kh[1] = '0;
    exp_tick    = 1'b0;
    exp_level   = '0;
    exp_press   = '0;
    exp_release = '0;
    for (int k = 0; k < NK; k++) streak[k] = 0;
  endtask

  task automatic model_step();
    logic ks;
    exp_press   = '0;
    exp_release = '0;
    if (exp_tick) begin
      for (int k = 0; k < NK; k++) begin
        ks = (AL != 0) ? ~kh[1][k] : kh[1][k];
        if (ks != exp_level[k]) begin
          streak[k]++;
          if (streak[k] == ST) begin
            exp_level[k] = ks;
            if (ks) exp_press[k] = 1'b1;
            else    exp_release[k] = 1'b1;
            streak[k] = 0;
          end
        end else begin
          streak[k] = 0;
        end
      end
    end
    kh[1] = kh[0];
    kh[0] = bus.key_raw;
    s_hist[3] = s_hist[2];
    s_hist[2] = s_hist[1];
    s_hist[1] = s_hist[0];
    s_hist[0] = slow_clk;
    exp_tick  = s_hist[2] & ~s_hist[3];
  endtask

  initial begin : model
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_clear();
      else        model_step();
    end
  end

  initial begin : compare
    forever begin
      @(posedge clock);
      #1;
      check("tick",        {31'd0, bus.tick}, {31'd0, exp_tick});
      check("key_level",   {28'd0, bus.key_level},   {28'd0, exp_level});
      check("key_press",   {28'd0, bus.key_press},   {28'd0, exp_press});
      check("key_release", {28'd0, bus.key_release}, {28'd0, exp_release});
    end
  end

  // ---------------- slow clock: 10 system clocks per period ----------------
  int slow_ph   = 0;
  int last_rise = -100;

  initial begin : slow_gen
    forever begin
      @(negedge clock);
      if (slow_run) begin
        slow_ph = (slow_ph == 9) ? 0 : slow_ph + 1;
        if (slow_ph == 5) begin
          slow_clk  = 1'b1;
          last_rise = cyc + 1;
        end else if (slow_ph == 0) begin
          slow_clk = 1'b0;
        end
      end
    end
  end

  // ---------------- tick timing and activity watchers ----------------
  logic          tim_en     = 1'b0;
  int            last_tick  = -1;
  logic [NK-1:0] watch_mask = '0;
  logic          watch_hold = 1'b0;
  logic          activity   = 1'b0;

  initial begin : watchers
    forever begin
      @(posedge clock);
      #1;
      if (tim_en && bus.tick) begin
        check("tick_delay", cyc - last_rise, 2);
        if (last_tick >= 0) check("tick_period", cyc - last_tick, 10);
        last_tick = cyc;
      end
      if (|((bus.key_press | bus.key_release | bus.key_level) & watch_mask)) activity = 1'b1;
      if (watch_hold && (bus.tick || |bus.key_press || |bus.key_release)) activity = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_keys(input logic [NK-1:0] v);
    @(negedge clock);
    bus.key_raw = v;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 40; i++) begin
      cyc_step();
      if (bus.tick) return;
    end
    check("wait_tick_timeout", 1, 0);
  endtask

  // Counts DUT ticks until the chosen pulse on key idx shows; -1 on timeout.
  task automatic ticks_until_pulse(input logic rel, input int idx, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      cyc_step();
      if (rel ? bus.key_release[idx] : bus.key_press[idx]) return;
      if (bus.tick) n++;
    end
    n = -1;
  endtask

  // Press/release after a tick so the synced change lands well before the next one.
  task automatic drive_after_tick(input logic [NK-1:0] v);
    wait_tick();
    repeat (3) cyc_step();
    drive_keys(v);
  endtask

  int n;

  initial begin : main
    bus.key_raw = '0;
    // Reset held with every key pressed (active-low pins at 0).
    repeat (5) cyc_step();
    check("rst_level",   {28'd0, bus.key_level},   0);
    check("rst_press",   {28'd0, bus.key_press},   0);
    check("rst_release", {28'd0, bus.key_release}, 0);
    check("rst_tick",    {31'd0, bus.tick},        0);

    @(negedge clock);
    reset    = 1'b1;
    slow_run = 1'b1;
    tim_en   = 1'b1;
    ticks_until_pulse(1'b0, 0, n);
    check("post_rst_ticks", n, ST);
    check("post_rst_press_all", {28'd0, bus.key_press}, 4'hF);
    drive_keys(4'hF);
    ticks_until_pulse(1'b1, 0, n);
    check("post_rst_release_ticks", n, ST);

    // Clean press and release of key 0.
    drive_after_tick(4'b1110);
    ticks_until_pulse(1'b0, 0, n);
    check("k0_press_ticks", n, 4);
    check("k0_level_with_press", {31'd0, bus.key_level[0]}, 1);
    cyc_step();
    check("k0_press_one_clock", {31'd0, bus.key_press[0]}, 0);
    drive_after_tick(4'b1111);
    ticks_until_pulse(1'b1, 0, n);
    check("k0_release_ticks", n, 4);
    check("k0_level_with_release", {31'd0, bus.key_level[0]}, 0);
    cyc_step();
    check("k0_release_one_clock", {31'd0, bus.key_release[0]}, 0);

    // Key 1 flips on alternate ticks for 12 ticks: nothing may be accepted.
    activity   = 1'b0;
    watch_mask = 4'b0010;
    for (int i = 0; i < 12; i++) drive_after_tick((i % 2 == 0) ? 4'b1101 : 4'b1111);
    repeat (2) wait_tick();
    watch_mask = '0;
    check("k1_bounce_quiet", {31'd0, activity}, 0);
    drive_after_tick(4'b1101);
    ticks_until_pulse(1'b0, 1, n);
    check("k1_stable_press_ticks", n, 4);
    drive_after_tick(4'b1111);
    ticks_until_pulse(1'b1, 1, n);
    check("k1_release_ticks", n, 4);
    tim_en = 1'b0;

    // Key 2 reaches PRESS_WAIT with 3 samples, then a one-clock reset.
    activity   = 1'b0;
    watch_mask = 4'b0100;
    drive_after_tick(4'b1011);
    repeat (3) wait_tick();
    repeat (2) cyc_step();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("k2_rst_level", {28'd0, bus.key_level}, 0);
    watch_mask = '0;
    check("k2_no_press_before_rst", {31'd0, activity}, 0);
    ticks_until_pulse(1'b0, 2, n);
    check("k2_fresh_ticks", n, 4);
    drive_after_tick(4'b1111);
    ticks_until_pulse(1'b1, 2, n);
    check("k2_release_ticks", n, 4);

    // Keys 0 and 3 together, then freeze slow_clk and wiggle the pins.
    drive_after_tick(4'b0110);
    ticks_until_pulse(1'b0, 0, n);
    check("simul_ticks", n, 4);
    check("simul_press", {28'd0, bus.key_press}, 4'b1001);
    @(negedge clock);
    slow_run = 1'b0;
    repeat (5) cyc_step();
    activity   = 1'b0;
    watch_hold = 1'b1;
    drive_keys(4'hF);
    repeat (25) cyc_step();
    drive_keys(4'h0);
    repeat (25) cyc_step();
    watch_hold = 1'b0;
    check("frozen_quiet", {31'd0, activity}, 0);
    check("frozen_level", {28'd0, bus.key_level}, 4'b1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_tick.md
Name: key_debounce_tick

Overview:
- Debounces the calculator's push-button inputs. Each key is sampled only on ticks derived from the 1 kHz divided clock that the clock-divider chain produces.
- Emits a clean level, a one-cycle press pulse and a one-cycle release pulse per key, all in the 50 MHz system-clock domain.
- Sits directly downstream of the divider chain and upstream of the operand/operator entry logic.

Parameters:
- NUM_KEYS, 4, number of independent keys debounced.
- STABLE_TICKS, 20, consecutive agreeing tick samples required to accept a change (20 ms at 1 kHz); legal range 2..255.
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (inverted after synchronisation); 0 = active-high.

Ports:
- clock, input, 1, 50 MHz system clock.
- reset, input, 1, asynchronous active-low reset; 0 resets all state.
- slow_clk, input, 1, 1 kHz divided clock from the divider chain; treated as asynchronous data, never used as a clock.
- key_raw, input, NUM_KEYS, raw button pins, asynchronous.
- key_level, output, NUM_KEYS, debounced level per key, 1 = pressed.
- key_press, output, NUM_KEYS, one-clock pulse on accepted press.
- key_release, output, NUM_KEYS, one-clock pulse on accepted release.
- tick, output, 1, internal sample strobe, exported for neighbours and debug.

Behaviour:
- Reset (reset=0, async): all sync flops, edge register, tick, counters, FSMs and outputs go to 0; every FSM enters RELEASED. Deassertion takes effect on the next clock edge.
- Tick generation:
  - slow_clk passes through a 2-flop synchroniser, then a previous-value register.
  - tick=1 for exactly one clock when synced=1 and prev=0.
  - tick rises on the 3rd clock edge after the slow_clk rising edge. At most one tick per slow_clk period.
- Key sync: each key_raw bit has its own 2-flop synchroniser, then is inverted if ACTIVE_LOW=1. Result is k_s (1 = pressed).
- Per-key FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. It acts only on cycles with tick=1 and holds otherwise.
  - RELEASED: on a tick with k_s=1, load cnt=1 and go to PRESS_WAIT.
  - PRESS_WAIT, on a tick:
    - k_s=0: cnt=0, return to RELEASED; no pulse.
    - k_s=1 and cnt==STABLE_TICKS-1: go to PRESSED, cnt=0.
    - otherwise cnt+1.
  - PRESSED: on a tick with k_s=0, load cnt=1 and go to RELEASE_WAIT.
  - RELEASE_WAIT: mirror of PRESS_WAIT with k_s inverted. On acceptance go to RELEASED; on a bounce (k_s=1) return to PRESSED.
- Acceptance rule: a change is accepted after exactly STABLE_TICKS consecutive tick samples all showing the new value.
- Outputs (registered):
  - key_level=1 exactly when the FSM is in PRESSED or RELEASE_WAIT. It changes on the clock edge where the accepting tick is consumed.
  - key_press / key_release go high on that same edge for exactly one clock.
- Counter width: clog2(STABLE_TICKS+1) bits, internal. The counter never exceeds STABLE_TICKS-1, so there is no wrap.
- Simultaneous events:
  - Keys are fully independent; several keys may pulse in the same cycle.
  - A raw change between ticks is invisible; only the tick samples matter.
- Mid-operation reset: any state, including a WAIT state with partial count, returns to RELEASED with cnt=0. No pulses are emitted during or on exit from reset.
- slow_clk stopped: no ticks occur, so all FSMs and outputs hold indefinitely.

Decomposition:
- Shared package holds:
  - the state encoding constants (RELEASED=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3);
  - the STABLE_TICKS default;
  - the count-width function.
- One sub-module, key_debounce_fsm (single key: state, counter, level/pulse registers). It is instantiated NUM_KEYS times in a generate loop.
- Top level owns the tick generator and the key synchronisers.

Test Plan:
- Reset: hold reset=0 for 5 clocks with key_raw=4'b0000 (ACTIVE_LOW=1, i.e. all pressed). Require key_level=0, key_press=0, key_release=0, tick=0. After release, require key_level[k]=1 only after STABLE_TICKS ticks.
- Tick timing: slow_clk period 10 clocks, STABLE_TICKS=4. Require tick high 1 clock, 3 clocks after each slow_clk rise, every 10 clocks.
- Clean press: key0 pressed and held. Require key_press[0] as a single 1-clock pulse coinciding with the 4th tick after the synced change, and key_level[0] rising on the same edge. Release gives a mirror key_release[0].
- Bounce rejection: key1 toggles pressed/released on alternate ticks for 12 ticks. Require key_level[1]=0 and no pulses throughout. A subsequent 4-tick stable press is accepted.
- Reset mid-count: key2 in PRESS_WAIT with cnt=3, assert reset for 1 clock. Require no key_press[2], and a fresh 4 ticks needed after reset.
- Simultaneous: keys 0 and 3 pressed on the same cycle. Require key_press=4'b1001 in one cycle; slow_clk held static => no further state change.
